// File: rtl/agg_bus_arbiter_if.sv
// Aggregate bus between NUM_MST requesting masters, the arbiter and one shared slave.
// The arbiter takes the master modport (it masters the slave); the agents take slave.
interface agg_bus_arbiter_if #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4
);
  logic [NUM_MST-1:0]        mst_valid;
  logic [NUM_MST*ADDR_W-1:0] mst_addr;
  logic [NUM_MST*DATA_W-1:0] mst_wdata;
  logic [NUM_MST-1:0]        mst_ready;
  logic [DATA_W-1:0]         mst_rdata;
  logic                      mst_err;
  logic                      slv_valid;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [DATA_W-1:0]         slv_rdata;
  logic                      slv_ready;

  modport master (
    input  mst_valid, mst_addr, mst_wdata, slv_rdata, slv_ready,
    output mst_ready, mst_rdata, mst_err, slv_valid, slv_addr, slv_wdata
  );

  modport slave (
    output mst_valid, mst_addr, mst_wdata, slv_rdata, slv_ready,
    input  mst_ready, mst_rdata, mst_err, slv_valid, slv_addr, slv_wdata
  );
endinterface

// File: rtl/agg_bus_arbiter.sv
// Round-robin arbiter sharing one request/response slave between NUM_MST masters,
// with an optional slave-response timeout that completes the request with an error.
module agg_bus_arbiter #(
  parameter int NUM_MST  = 2,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int TIMEOUT  = 15,
  localparam int GW      = (NUM_MST > 2) ? $clog2(NUM_MST) : 1
) (
  input  logic              clock,
  input  logic              reset,
  agg_bus_arbiter_if.master bus,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);
  localparam int CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     r_grant_id;
  logic [ADDR_W-1:0] r_slv_addr;
  logic [DATA_W-1:0] r_slv_wdata;
  logic [DATA_W-1:0] r_mst_rdata;
  logic              r_err;
  logic [CW-1:0]     r_cnt;

  state_t            w_state_nxt;
  logic [GW-1:0]     w_last_nxt;
  logic [GW-1:0]     w_grant_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_err_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [GW-1:0]     w_winner;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  // Lowest rotation offset wins, so scan from the far end and let nearer hits overwrite.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                            input logic [GW-1:0]      last);
    logic [NUM_MST-1:0] sh;
    int                 idx;
    rr_pick = last;
    for (int i = NUM_MST; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_MST;
      sh  = req >> idx;
      if (sh[0]) begin
        rr_pick = GW'(idx);
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  assign w_winner    = rr_pick(bus.mst_valid, r_last_grant);
  assign w_win_addr  = ADDR_W'(bus.mst_addr >> (int'(w_winner) * ADDR_W));
  assign w_win_wdata = DATA_W'(bus.mst_wdata >> (int'(w_winner) * DATA_W));

  // Next-state and next-register values for the IDLE/ISSUE/RESP transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_grant_nxt = r_grant_id;
    w_addr_nxt  = r_slv_addr;
    w_wdata_nxt = r_slv_wdata;
    w_rdata_nxt = r_mst_rdata;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|bus.mst_valid) begin
          w_state_nxt = S_ISSUE;
          w_last_nxt  = w_winner;
          w_grant_nxt = w_winner;
          w_addr_nxt  = w_win_addr;
          w_wdata_nxt = w_win_wdata;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        // A response in the final allowed cycle still counts as a normal completion.
        if (bus.slv_ready) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = bus.slv_rdata;
          w_err_nxt   = 1'b0;
        end else if ((TIMEOUT != 0) && (r_cnt == CW'(CNT_LAST))) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = {DATA_W{1'b0}};
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1'b1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(NUM_MST - 1);
      r_grant_id   <= {GW{1'b0}};
      r_slv_addr   <= {ADDR_W{1'b0}};
      r_slv_wdata  <= {DATA_W{1'b0}};
      r_mst_rdata  <= {DATA_W{1'b0}};
      r_err        <= 1'b0;
      r_cnt        <= {CW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_grant_id   <= w_grant_nxt;
      r_slv_addr   <= w_addr_nxt;
      r_slv_wdata  <= w_wdata_nxt;
      r_mst_rdata  <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign bus.slv_valid = (r_state == S_ISSUE);
  assign bus.slv_addr  = r_slv_addr;
  assign bus.slv_wdata = r_slv_wdata;
  assign bus.mst_rdata = r_mst_rdata;
  assign bus.mst_err   = (r_state == S_RESP) && r_err;
  assign bus.mst_ready = (r_state == S_RESP) ? (NUM_MST'(1'b1) << r_grant_id)
                                             : {NUM_MST{1'b0}};
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_grant_id;
endmodule

// File: tb/tb_agg_bus_arbiter.sv
// Directed bench for agg_bus_arbiter: a table of single-master transactions followed
// by hand-written contention, wait-state, reset and back-to-back sequences.
module tb_agg_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          busy;
  logic [0:0]    grant_id;
  int            n_checks = 0;
  int            n_err    = 0;

  int            delay   = 0;
  logic [DW-1:0] rd_mask = 4'h0;
  int            vcnt    = 0;

  always #5 clock = ~clock;

  agg_bus_arbiter_if #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  agg_bus_arbiter #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // Slave model: answers after `delay` wait cycles (negative = never), data = wdata ^ mask.
  always @(posedge clock) vcnt <= bus.slv_valid ? vcnt + 1 : 0;
  assign bus.slv_ready = bus.slv_valid && (delay >= 0) && (vcnt == delay);
  assign bus.slv_rdata = bus.slv_wdata ^ rd_mask;

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;
    logic [DW-1:0] mask;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_vcyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mst_addr[m*AW +: AW]  = a;
    bus.mst_wdata[m*DW +: DW] = d;
    bus.mst_valid[m]          = 1'b1;
  endtask

  task automatic wait_pulse(input int limit, output int k, output logic got);
    k   = 0;
    got = 1'b0;
    while (!got && k < limit) begin
      @(negedge clock);
      k++;
      if (bus.mst_ready != 2'b00) got = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            k;
    int            vc;
    int            last_k;
    int            pulses;
    logic          got;
    logic          ok;
    logic [NM-1:0] exp_rdy;
    logic [DW-1:0] exp_d;

    vecs[0] = '{0, 4'hC, 4'hC,  0, 4'h0, 4'hC, 1'b0,  2,  1};
    vecs[1] = '{1, 4'h5, 4'hA,  0, 4'hF, 4'h5, 1'b0,  2,  1};
    vecs[2] = '{0, 4'h7, 4'h3,  5, 4'h0, 4'h3, 1'b0,  7,  6};
    vecs[3] = '{1, 4'hF, 4'h0, -1, 4'h0, 4'h0, 1'b1, 16, 15};
    vecs[4] = '{0, 4'h1, 4'h9, 14, 4'h6, 4'hF, 1'b0, 16, 15};
    vecs[5] = '{1, 4'h0, 4'hF, 13, 4'h0, 4'hF, 1'b0, 15, 14};
    vecs[6] = '{0, 4'h2, 4'h6, -1, 4'h5, 4'h0, 1'b1, 16, 15};

    reset         = 1'b1;
    bus.mst_valid = 2'b00;
    bus.mst_addr  = 8'h00;
    bus.mst_wdata = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_slv_valid", {31'd0, bus.slv_valid}, 32'd0);
    check("rst_slv_addr",  {28'd0, bus.slv_addr},  32'd0);
    check("rst_slv_wdata", {28'd0, bus.slv_wdata}, 32'd0);
    check("rst_mst_ready", {30'd0, bus.mst_ready}, 32'd0);
    check("rst_mst_rdata", {28'd0, bus.mst_rdata}, 32'd0);
    check("rst_mst_err",   {31'd0, bus.mst_err},   32'd0);
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_grant_id",  {31'd0, grant_id},      32'd0);

    for (int v = 0; v < 7; v++) begin
      @(negedge clock);
      delay   = vecs[v].dly;
      rd_mask = vecs[v].mask;
      set_req(vecs[v].m, vecs[v].addr, vecs[v].wdata);
      k = 0; vc = 0; ok = 1'b1; got = 1'b0;
      while (!got && k < 40) begin
        @(negedge clock);
        k++;
        if (bus.slv_valid) begin
          vc++;
          if (bus.slv_addr !== vecs[v].addr || bus.slv_wdata !== vecs[v].wdata) ok = 1'b0;
        end
        if (bus.mst_ready != 2'b00) got = 1'b1;
      end
      exp_rdy = 2'b01 << vecs[v].m;
      check($sformatf("v%0d_done", v),    {31'd0, got}, 32'd1);
      check($sformatf("v%0d_ready", v),   {30'd0, bus.mst_ready}, {30'd0, exp_rdy});
      check($sformatf("v%0d_rdata", v),   {28'd0, bus.mst_rdata}, {28'd0, vecs[v].exp_rdata});
      check($sformatf("v%0d_err", v),     {31'd0, bus.mst_err},   {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_latency", v), k,  vecs[v].exp_lat);
      check($sformatf("v%0d_vcycles", v), vc, vecs[v].exp_vcyc);
      check($sformatf("v%0d_addr_stable", v), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d_grant_id", v), {31'd0, grant_id}, vecs[v].m);
      bus.mst_valid = 2'b00;
      @(negedge clock);
      check($sformatf("v%0d_idle_busy", v),  {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_idle_ready", v), {30'd0, bus.mst_ready}, 32'd0);
    end

    // Contention: last grant was master 0, so service alternates 1,0,1,... every 3 cycles.
    @(negedge clock);
    delay = 0; rd_mask = 4'h0;
    set_req(0, 4'h1, 4'h1);
    set_req(1, 4'h2, 4'h2);
    k = 0; pulses = 0; last_k = 0;
    while (pulses < 6 && k < 40) begin
      @(negedge clock);
      k++;
      if (bus.mst_ready != 2'b00) begin
        exp_rdy = (pulses % 2 == 0) ? 2'b10 : 2'b01;
        exp_d   = (pulses % 2 == 0) ? 4'h2 : 4'h1;
        check($sformatf("cont%0d_ready", pulses), {30'd0, bus.mst_ready}, {30'd0, exp_rdy});
        check($sformatf("cont%0d_rdata", pulses), {28'd0, bus.mst_rdata}, {28'd0, exp_d});
        check($sformatf("cont%0d_gap", pulses), k - last_k, (pulses == 0) ? 2 : 3);
        last_k = k;
        pulses++;
      end
    end
    check("cont_pulses", pulses, 6);
    bus.mst_valid = 2'b00;
    @(negedge clock);

    // Wait states: master 1 stalls 5 cycles while master 0 queues behind it.
    @(negedge clock);
    delay = 5;
    set_req(1, 4'h6, 4'h6);
    @(negedge clock);
    set_req(0, 4'h9, 4'h9);
    k = 1; vc = 1; ok = 1'b1; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (bus.slv_valid) begin
        vc++;
        if (bus.slv_addr !== 4'h6) ok = 1'b0;
      end
      if (bus.mst_ready != 2'b00) got = 1'b1;
    end
    check("ws_first_ready", {30'd0, bus.mst_ready}, 32'd2);
    check("ws_first_lat", k, 7);
    check("ws_vcycles", vc, 6);
    check("ws_addr_stable", {31'd0, ok}, 32'd1);
    bus.mst_valid[1] = 1'b0;
    delay = 0;
    wait_pulse(40, k, got);
    check("ws_second_ready", {30'd0, bus.mst_ready}, 32'd1);
    check("ws_second_lat", k, 3);
    check("ws_second_rdata", {28'd0, bus.mst_rdata}, 32'h9);
    bus.mst_valid = 2'b00;
    @(negedge clock);

    // Reset during master 0's ISSUE: abandoned, and master 0 regains first priority.
    @(negedge clock);
    delay = -1;
    set_req(0, 4'hB, 4'hB);
    repeat (3) @(negedge clock);
    check("rmid_in_issue", {31'd0, bus.slv_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rmid_slv_valid", {31'd0, bus.slv_valid}, 32'd0);
    check("rmid_busy",      {31'd0, busy},          32'd0);
    check("rmid_ready",     {30'd0, bus.mst_ready}, 32'd0);
    check("rmid_err",       {31'd0, bus.mst_err},   32'd0);
    delay = 0;
    set_req(0, 4'hA, 4'hA);
    set_req(1, 4'h4, 4'h4);
    wait_pulse(40, k, got);
    check("rmid_prio_ready", {30'd0, bus.mst_ready}, 32'd1);
    check("rmid_prio_lat", k, 2);
    bus.mst_valid[0] = 1'b0;
    wait_pulse(40, k, got);
    check("rmid_next_ready", {30'd0, bus.mst_ready}, 32'd2);
    check("rmid_next_rdata", {28'd0, bus.mst_rdata}, 32'h4);

    // Back-to-back: master 1 keeps valid through its pulse with a new address.
    set_req(1, 4'h8, 4'h8);
    wait_pulse(40, k, got);
    check("b2b_first_ready", {30'd0, bus.mst_ready}, 32'd2);
    check("b2b_first_rdata", {28'd0, bus.mst_rdata}, 32'h8);
    set_req(1, 4'h3, 4'h3);
    @(negedge clock);
    check("b2b_gap_valid", {31'd0, bus.slv_valid}, 32'd0);
    @(negedge clock);
    check("b2b_issue_valid", {31'd0, bus.slv_valid}, 32'd1);
    check("b2b_issue_addr",  {28'd0, bus.slv_addr},  32'h3);
    check("b2b_grant_id",    {31'd0, grant_id},      32'd1);
    @(negedge clock);
    check("b2b_second_ready", {30'd0, bus.mst_ready}, 32'd2);
    check("b2b_second_rdata", {28'd0, bus.mst_rdata}, 32'h3);
    bus.mst_valid = 2'b00;
    @(negedge clock);
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/agg_bus_arbiter.md
# agg_bus_arbiter

Round-robin arbiter that shares one aggregate slave bus (valid/addr/wdata out, rdata/ready back) between `NUM_MST` masters. It sits between the master instances and a single slave instance, in place of a point-to-point master–slave connection. Each transaction is a single request/response:
- the arbiter registers the winning request;
- it drives the slave until `slv_ready`;
- it returns read data to the granted master;
- it returns an error response if the slave does not answer within `TIMEOUT` cycles.

## Interface
Parameters:
- `NUM_MST`, default 2: number of masters, legal range 2..4.
- `ADDR_W`, default 4: address width.
- `DATA_W`, default 4: write/read data width.
- `TIMEOUT`, default 15: maximum number of ISSUE cycles without `slv_ready`; 0 disables the timeout.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `mst_valid`  in  NUM_MST: per-master request.
  - Held high, with addr/wdata stable, until that master's `mst_ready` pulse.
- `mst_addr`  in  NUM_MST*ADDR_W: packed; master i occupies bits [i*ADDR_W +: ADDR_W].
- `mst_wdata`  in  NUM_MST*DATA_W: packed, same layout as `mst_addr`.
- `mst_ready`  out  NUM_MST: one-hot, single-cycle completion pulse.
- `mst_rdata`  out  DATA_W: response data, broadcast to all masters; qualified by `mst_ready`.
- `mst_err`  out  1: timeout flag, qualified by `mst_ready`.
- `slv_valid`  out  1: request to the slave.
- `slv_addr`  out  ADDR_W: registered address.
- `slv_wdata`  out  DATA_W: registered write data.
- `slv_rdata`  in  DATA_W: slave read data.
- `slv_ready`  in  1: slave completion, sampled only while `slv_valid` is high.
- `busy`  out  1: high whenever the state is not IDLE.
- `grant_id`  out  max(1,clog2(NUM_MST)): index of the current or most recent grant.

## Operation
State machine: IDLE, ISSUE, RESP.

**IDLE**
- When `mst_valid` is nonzero: select the winner by round-robin, searching from `last_grant+1` modulo `NUM_MST` upward.
- At the edge: latch the winner's addr/wdata into `slv_addr`/`slv_wdata`, set `grant_id` = `last_grant` = winner, clear the timeout counter, go to ISSUE.
- When `mst_valid` is zero: stay in IDLE.

**ISSUE**
- `slv_valid` = 1.
- If `slv_ready` = 1: capture `slv_rdata` into `mst_rdata`, clear the error flag, go to RESP.
- Else, if `TIMEOUT` != 0 and the counter equals `TIMEOUT-1`: set `mst_rdata` = 0 and the error flag = 1, go to RESP.
- Otherwise: increment the counter.
- If `slv_ready` and timeout occur in the same cycle, `slv_ready` wins (normal response, `mst_err` = 0).

**RESP**
- `mst_ready[grant_id]` = 1 for exactly one cycle; `mst_err` reflects the flag.
- Unconditionally go to IDLE.

**Request handling**
- `mst_valid` is sampled only in IDLE, so a master holding valid across its ready pulse is treated as a new request in the next IDLE cycle. There is no double issue.
- Deasserting `mst_valid` before completion is illegal; behaviour is undefined.
- Requests from non-granted masters wait; they are never dropped.
- The round-robin guarantees each persistent requester is served within `NUM_MST` transactions.

**Reset values**
- State IDLE.
- `slv_valid` 0, `slv_addr` 0, `slv_wdata` 0.
- `mst_ready` 0, `mst_rdata` 0, `mst_err` 0.
- `busy` 0, `grant_id` 0.
- `last_grant` = NUM_MST-1, so master 0 has first priority.
- Timeout counter 0.

**Reset mid-transaction**
- Next edge returns to IDLE and drops `slv_valid`.
- The in-flight transaction is abandoned: no `mst_ready`, no error.

## Timing
- Request visible in cycle t (IDLE) → `slv_valid` high in t+1.
- `slv_ready` in cycle s → `mst_ready` pulse and data in s+1 → IDLE in s+2.
- Minimum request-to-ready latency: 2 cycles (t+2). Peak throughput: one transaction per 3 cycles.
- Timeout: `slv_valid` is high for exactly `TIMEOUT` cycles; `mst_ready` with `mst_err` = 1 follows in the next cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `mst_*` inputs to `slv_*` outputs.

## Test plan
- **Single master:** after reset, master 0 requests addr 0xC / wdata 0xC; slave echoes wdata with `slv_ready` in its first ISSUE cycle. Expect:
  - `slv_valid` at t+1;
  - `mst_ready` = 2'b01, `mst_rdata` = 0xC, `mst_err` = 0 at t+2;
  - `busy` low at t+3.
- **Contention:** both masters hold valid continuously with an immediate-ready slave. Expect grants alternating 0,1,0,1 and `mst_ready` pulses every 3 cycles.
- **Slave wait states:** slave delays `slv_ready` by 5 cycles. Expect:
  - `slv_valid` high for 6 cycles with addr/wdata stable;
  - `mst_ready` the cycle after `slv_ready`;
  - other master's request unserved until then.
- **Timeout:** `TIMEOUT` = 15, slave never responds. Expect `slv_valid` high for 15 cycles, then `mst_ready` with `mst_rdata` = 0, `mst_err` = 1. Repeat with `slv_ready` asserted exactly in the 15th cycle: expect `mst_err` = 0 and `slv_rdata` returned.
- **Reset mid-ISSUE:** assert `reset` for 1 cycle during ISSUE. Expect:
  - next cycle: `slv_valid` 0, `busy` 0, no `mst_ready`;
  - master 0 regains first priority afterwards.
- **Back-to-back same master:** master 1 keeps valid high through its ready pulse with new addr 0x3. Expect a second issue to start two cycles after the first ready, with `slv_addr` = 0x3.
